// File: rtl/mem_router_pkg.sv
// Shared types, error codes and helpers for the memory region router.
// Both the router top and its region decoder import this package.
package mem_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_RESP
    } state_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_SIZE     = 3'd1;
    localparam logic [2:0] ERR_UNMAPPED = 3'd2;
    localparam logic [2:0] ERR_ALIGN    = 3'd3;
    localparam logic [2:0] ERR_READONLY = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd5;

    localparam logic [1:0] SIZE_BYTE    = 2'd0;
    localparam logic [1:0] SIZE_HALF    = 2'd1;
    localparam logic [1:0] SIZE_WORD    = 2'd2;
    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    // Widest address supported; the extra top bit of the result is the carry.
    localparam int ADDR_MAX_W = 64;

    function automatic logic [ADDR_MAX_W:0] end_address(input logic [ADDR_MAX_W-1:0] addr,
                                                        input logic [1:0]            size);
        logic [ADDR_MAX_W:0] span;
        case (size)
            SIZE_BYTE: span = (ADDR_MAX_W+1)'(0);
            SIZE_HALF: span = (ADDR_MAX_W+1)'(1);
            SIZE_WORD: span = (ADDR_MAX_W+1)'(3);
            default:   span = (ADDR_MAX_W+1)'(7);
        endcase
        return {1'b0, addr} + span;
    endfunction

    function automatic logic [31:0] zero_extend(input logic [31:0] data, input logic [1:0] size);
        case (size)
            SIZE_BYTE: return {24'b0, data[7:0]};
            SIZE_HALF: return {16'b0, data[15:0]};
            default:   return data;
        endcase
    endfunction

endpackage

// File: rtl/mem_region_router_region_decoder.sv
// Combinational address decode: picks the lowest-indexed region containing the
// whole access and classifies the request by error priority.
module region_decoder
    import mem_router_pkg::*;
#(
    parameter int                          ADDR_W              = 32,
    parameter int                          N_REGIONS           = 4,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE         = {32'd516, 32'd512, 32'd256, 32'd0},
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_LIMIT        = {32'd519, 32'd515, 32'd511, 32'd255},
    parameter logic [N_REGIONS-1:0]        REGION_WRITABLE     = 4'b1010,
    parameter logic [N_REGIONS-1:0]        REGION_ALIGN_EXEMPT = 4'b0001
) (
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [1:0]           size_i,
    input  logic                 we_i,
    output logic                 hit_o,
    output logic [N_REGIONS-1:0] sel_o,
    output logic [2:0]           err_code_o
);

    logic [ADDR_MAX_W:0] ext;
    logic                carry;
    logic [ADDR_W-1:0]   end_addr;
    logic [ADDR_W-1:0]   base;
    logic [ADDR_W-1:0]   limit;
    logic                exempt;
    logic                writable;
    logic                misaligned;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        ext        = end_address(ADDR_MAX_W'(addr_i), size_i);
        carry      = |ext[ADDR_MAX_W:ADDR_W];
        end_addr   = ext[ADDR_W-1:0];
        hit_o      = 1'b0;
        sel_o      = '0;
        exempt     = 1'b0;
        writable   = 1'b0;
        base       = '0;
        limit      = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            base  = REGION_BASE[i*ADDR_W +: ADDR_W];
            limit = REGION_LIMIT[i*ADDR_W +: ADDR_W];
            if (!carry && (addr_i >= base) && (end_addr <= limit)) begin
                hit_o    = 1'b1;
                sel_o    = '0;
                sel_o[i] = 1'b1;
                exempt   = REGION_ALIGN_EXEMPT[i];
                writable = REGION_WRITABLE[i];
            end
        end

        misaligned = ((size_i == SIZE_HALF) && addr_i[0]) ||
                     ((size_i == SIZE_WORD) && (addr_i[1:0] != 2'b00));

        if (size_i == SIZE_ILLEGAL) begin
            err_code_o = ERR_SIZE;
        end else if (!hit_o) begin
            err_code_o = ERR_UNMAPPED;
        end else if (misaligned && !exempt) begin
            err_code_o = ERR_ALIGN;
        end else if (we_i && !writable) begin
            err_code_o = ERR_READONLY;
        end else begin
            err_code_o = ERR_NONE;
        end
    end

endmodule

// File: rtl/mem_region_router.sv
// Routes one CPU load/store at a time to an address-mapped region with checks,
// a bounded target wait and sticky error status.
module mem_region_router
    import mem_router_pkg::*;
#(
    parameter int                          ADDR_W              = 32,
    parameter int                          DATA_W              = 32,
    parameter int                          N_REGIONS           = 4,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE         = {32'd516, 32'd512, 32'd256, 32'd0},
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_LIMIT        = {32'd519, 32'd515, 32'd511, 32'd255},
    parameter logic [N_REGIONS-1:0]        REGION_WRITABLE     = 4'b1010,
    parameter logic [N_REGIONS-1:0]        REGION_ALIGN_EXEMPT = 4'b0001,
    parameter int                          TIMEOUT_CYCLES      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic                        req_we,
    input  logic [1:0]                  req_size,
    input  logic [DATA_W-1:0]           req_wdata,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_error,
    output logic [2:0]                  rsp_err_code,
    output logic [N_REGIONS-1:0]        tgt_valid,
    output logic [ADDR_W-1:0]           tgt_addr,
    output logic                        tgt_we,
    output logic [1:0]                  tgt_size,
    output logic [DATA_W-1:0]           tgt_wdata,
    input  logic [N_REGIONS-1:0]        tgt_ready,
    input  logic [N_REGIONS*DATA_W-1:0] tgt_rdata,
    input  logic                        err_clear,
    output logic                        err_sticky,
    output logic [ADDR_W-1:0]           err_addr,
    output logic [2:0]                  err_code,
    output logic [7:0]                  err_count
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e               state_q, state_d;
    logic                 alive_q;
    logic [ADDR_W-1:0]    addr_q;
    logic                 we_q;
    logic [1:0]           size_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [N_REGIONS-1:0] sel_q;
    logic [ADDR_W-1:0]    tgt_addr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [DATA_W-1:0]    rdata_q;
    logic [2:0]           code_q;
    logic                 err_sticky_q;
    logic [ADDR_W-1:0]    err_addr_q;
    logic [2:0]           err_code_q;
    logic [7:0]           err_count_q;

    logic                 dec_hit;
    logic [N_REGIONS-1:0] dec_sel;
    logic [2:0]           dec_code;
    logic [ADDR_W-1:0]    base_sel;
    logic [DATA_W-1:0]    rdata_sel;
    logic                 sel_ready;
    logic                 timed_out;

    region_decoder #(
        .ADDR_W              (ADDR_W),
        .N_REGIONS           (N_REGIONS),
        .REGION_BASE         (REGION_BASE),
        .REGION_LIMIT        (REGION_LIMIT),
        .REGION_WRITABLE     (REGION_WRITABLE),
        .REGION_ALIGN_EXEMPT (REGION_ALIGN_EXEMPT)
    ) u_decoder (
        .addr_i     (addr_q),
        .size_i     (size_q),
        .we_i       (we_q),
        .hit_o      (dec_hit),
        .sel_o      (dec_sel),
        .err_code_o (dec_code)
    );

    always_comb begin
        base_sel  = '0;
        rdata_sel = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            if (dec_sel[i]) base_sel |= REGION_BASE[i*ADDR_W +: ADDR_W];
            if (sel_q[i])   rdata_sel |= tgt_rdata[i*DATA_W +: DATA_W];
        end
        sel_ready = |(tgt_ready & sel_q);
        timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid && alive_q) state_d = ST_CHECK;
            ST_CHECK: state_d = (dec_hit && dec_code == ERR_NONE) ? ST_ISSUE : ST_RESP;
            ST_ISSUE: if (sel_ready || timed_out) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // alive_q holds req_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            size_q     <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            tgt_addr_q <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            code_q     <= ERR_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && alive_q) begin
                        addr_q  <= req_addr;
                        we_q    <= req_we;
                        size_q  <= req_size;
                        wdata_q <= req_wdata;
                    end
                end
                ST_CHECK: begin
                    sel_q      <= (dec_code == ERR_NONE) ? dec_sel : '0;
                    tgt_addr_q <= addr_q - base_sel;
                    cnt_q      <= '0;
                    rdata_q    <= '0;
                    code_q     <= dec_code;
                end
                ST_ISSUE: begin
                    if (sel_ready) begin
                        rdata_q <= we_q ? '0 : zero_extend(rdata_sel, size_q);
                    end else if (timed_out) begin
                        code_q <= ERR_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // A new error in the same cycle as err_clear wins and restarts the count at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
            err_code_q   <= ERR_NONE;
            err_count_q  <= '0;
        end else if (state_q == ST_RESP && code_q != ERR_NONE) begin
            err_sticky_q <= 1'b1;
            err_addr_q   <= addr_q;
            err_code_q   <= code_q;
            if (err_clear)                  err_count_q <= 8'd1;
            else if (err_count_q != 8'hFF)  err_count_q <= err_count_q + 8'd1;
        end else if (err_clear) begin
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
            err_code_q   <= ERR_NONE;
            err_count_q  <= '0;
        end
    end

    assign req_ready    = (state_q == ST_IDLE) && alive_q;
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_rdata    = rsp_valid ? rdata_q : '0;
    assign rsp_error    = rsp_valid && (code_q != ERR_NONE);
    assign rsp_err_code = rsp_valid ? code_q : ERR_NONE;
    assign tgt_valid    = (state_q == ST_ISSUE) ? sel_q : '0;
    assign tgt_addr     = tgt_addr_q;
    assign tgt_we       = we_q;
    assign tgt_size     = size_q;
    assign tgt_wdata    = wdata_q;
    assign err_sticky   = err_sticky_q;
    assign err_addr     = err_addr_q;
    assign err_code     = err_code_q;
    assign err_count    = err_count_q;

endmodule
